// File: rtl/pulse_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : pulse_conditioner
// Brief    : Synchronises a raw pulse pin, glitch-filters it, and emits one
//            strobe per qualified rising edge with holdoff and event counters.
// Revision : 1.0
// ============================================================================
module pulse_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 1000,
    parameter int HOLDOFF_CYCLES = 100_000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    input  logic                 enable,
    output logic                 detection,
    output logic                 level,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pulse_count,
    output logic [15:0]          glitch_count,
    output logic [15:0]          reject_count
);

    localparam int QW = (FILTER_CYCLES < 2)  ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam int HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [QW-1:0]        c_q_one   = QW'(1);
    localparam logic [QW-1:0]        c_q_max   = QW'(FILTER_CYCLES);
    localparam logic [HW-1:0]        c_hold    = HW'(HOLDOFF_CYCLES);
    localparam logic [HW-1:0]        c_hold_one = HW'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_QUAL = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_QUAL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [QW-1:0]          r_q;
    logic [QW-1:0]          w_q_nxt;
    logic [HW-1:0]          r_hold;
    logic                   r_level;
    logic                   r_det;
    logic [CNT_WIDTH-1:0]   r_pulse_cnt;
    logic [15:0]            r_glitch_cnt;
    logic [15:0]            r_reject_cnt;
    logic                   w_s;
    logic                   w_busy;
    logic                   w_glitch;
    logic                   w_qual_rise;
    logic                   w_accept;
    logic                   w_reject;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_busy = (r_hold != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_state <= ST_LOW;
            r_q     <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], signal};
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Qualification runs on the synchronised level; a reversal before q hits
    // FILTER_CYCLES drops back to the previous stable state as a glitch.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_glitch    = 1'b0;
        w_qual_rise = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_RISE_QUAL;
                    w_q_nxt     = c_q_one;
                end
            end
            ST_RISE_QUAL: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                    w_glitch    = 1'b1;
                end else if (r_q == c_q_max) begin
                    w_state_nxt = ST_HIGH;
                    w_qual_rise = 1'b1;
                end else begin
                    w_q_nxt = r_q + c_q_one;
                end
            end
            ST_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_FALL_QUAL;
                    w_q_nxt     = c_q_one;
                end
            end
            ST_FALL_QUAL: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_glitch    = 1'b1;
                end else if (r_q == c_q_max) begin
                    w_state_nxt = ST_LOW;
                end else begin
                    w_q_nxt = r_q + c_q_one;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
            end
        endcase
        w_accept = w_qual_rise & enable & ~w_busy;
        w_reject = w_qual_rise & enable & w_busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level      <= 1'b0;
            r_det        <= 1'b0;
            r_hold       <= '0;
            r_pulse_cnt  <= '0;
            r_glitch_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            r_level <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALL_QUAL);
            r_det   <= w_accept;
            if (w_accept) begin
                r_hold <= c_hold;
            end else if (w_busy) begin
                r_hold <= r_hold - c_hold_one;
            end
            if (w_accept) begin
                r_pulse_cnt <= r_pulse_cnt + c_cnt_one;
            end
            if (w_glitch && (r_glitch_cnt != 16'hFFFF)) begin
                r_glitch_cnt <= r_glitch_cnt + 16'd1;
            end
            if (w_reject && (r_reject_cnt != 16'hFFFF)) begin
                r_reject_cnt <= r_reject_cnt + 16'd1;
            end
        end
    end

    assign detection    = r_det;
    assign level        = r_level;
    assign busy         = w_busy;
    assign pulse_count  = r_pulse_cnt;
    assign glitch_count = r_glitch_cnt;
    assign reject_count = r_reject_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pulse_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pulse_conditioner
// Brief    : Directed self-checking bench; instance A uses the default filter
//            with a shortened holdoff, instance B the minimal 1/0/4 variant.
// Revision : 1.0
// ============================================================================
module tb_pulse_conditioner;

    localparam int SA = 2;
    localparam int FA = 1000;
    localparam int HA = 5000;
    localparam int SB = 2;
    localparam int FB = 1;
    localparam int HB = 0;
    localparam int CB = 4;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    always #5 clk_a = ~clk_a;
    always #1 clk_b = ~clk_b;

    logic        rst_a, sig_a, en_a, det_a, lvl_a, busy_a;
    logic [31:0] pc_a;
    logic [15:0] gc_a, rc_a;
    logic        rst_b, sig_b, en_b, det_b, lvl_b, busy_b;
    logic [3:0]  pc_b;
    logic [15:0] gc_b, rc_b;

    pulse_conditioner #(
        .SYNC_STAGES(SA), .FILTER_CYCLES(FA), .HOLDOFF_CYCLES(HA), .CNT_WIDTH(32)
    ) u_dut_a (
        .clk(clk_a), .reset(rst_a), .signal(sig_a), .enable(en_a),
        .detection(det_a), .level(lvl_a), .busy(busy_a),
        .pulse_count(pc_a), .glitch_count(gc_a), .reject_count(rc_a)
    );

    pulse_conditioner #(
        .SYNC_STAGES(SB), .FILTER_CYCLES(FB), .HOLDOFF_CYCLES(HB), .CNT_WIDTH(CB)
    ) u_dut_b (
        .clk(clk_b), .reset(rst_b), .signal(sig_b), .enable(en_b),
        .detection(det_b), .level(lvl_b), .busy(busy_b),
        .pulse_count(pc_b), .glitch_count(gc_b), .reject_count(rc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Event monitors, sampled on the falling edge
    int cyc_a = 0, det_n_a = 0, det_cyc_a = 0, busy_n_a = 0, lvl_n_a = 0, det_nb_a = 0;
    int cyc_b = 0, det_n_b = 0, det_cyc_b = 0, busy_n_b = 0;

    always @(posedge clk_a) cyc_a <= cyc_a + 1;
    always @(posedge clk_b) cyc_b <= cyc_b + 1;

    always @(negedge clk_a) begin
        if (det_a === 1'b1) begin
            det_n_a   <= det_n_a + 1;
            det_cyc_a <= cyc_a;
            if (busy_a !== 1'b1) det_nb_a <= det_nb_a + 1;
        end
        if (busy_a === 1'b1) busy_n_a <= busy_n_a + 1;
        if (lvl_a === 1'b1)  lvl_n_a  <= lvl_n_a + 1;
    end

    always @(negedge clk_b) begin
        if (det_b === 1'b1) begin
            det_n_b   <= det_n_b + 1;
            det_cyc_b <= cyc_b;
        end
        if (busy_b === 1'b1) busy_n_b <= busy_n_b + 1;
    end

    task automatic wait_a(input int n);
        repeat (n) @(negedge clk_a);
    endtask

    task automatic wait_b(input int n);
        repeat (n) @(negedge clk_b);
    endtask

    task automatic pulse_a(input int hi, input int lo);
        sig_a = 1'b1;
        wait_a(hi);
        sig_a = 1'b0;
        wait_a(lo);
    endtask

    task automatic check_zero_a(input string tag);
        check_eq({tag, "_level"},  32'(lvl_a),  32'd0);
        check_eq({tag, "_det"},    32'(det_a),  32'd0);
        check_eq({tag, "_busy"},   32'(busy_a), 32'd0);
        check_eq({tag, "_pcount"}, pc_a,        32'd0);
        check_eq({tag, "_gcount"}, 32'(gc_a),   32'd0);
        check_eq({tag, "_rcount"}, 32'(rc_a),   32'd0);
    endtask

    task automatic run_a();
        int k, d0, b0, l0;
        wait_a(4);
        check_zero_a("a_reset");
        rst_a = 1'b1;
        wait_a(3);

        // Clean rise with defaults: strobe after SYNC+FILTER edges, then holdoff
        k  = cyc_a;
        d0 = det_n_a;
        b0 = busy_n_a;
        sig_a = 1'b1;
        wait_a(2000);
        check_eq("a_rise_det_count", 32'(det_n_a - d0), 32'd1);
        check_eq("a_rise_latency", 32'(det_cyc_a), 32'(k + 1 + SA + FA));
        check_eq("a_rise_level", 32'(lvl_a), 32'd1);
        check_eq("a_rise_pcount", pc_a, 32'd1);
        check_eq("a_rise_busy", 32'(busy_a), 32'd1);
        wait_a(HA);
        check_eq("a_holdoff_len", 32'(busy_n_a - b0), 32'(HA));
        check_eq("a_holdoff_done", 32'(busy_a), 32'd0);
        check_eq("a_det_with_busy", 32'(det_nb_a), 32'd0);
        sig_a = 1'b0;
        wait_a(1100);
        check_eq("a_fall_level", 32'(lvl_a), 32'd0);
        check_eq("a_fall_no_det", 32'(det_n_a - d0), 32'd1);

        // Pulses one cycle shorter than the filter are glitches
        d0 = det_n_a;
        l0 = lvl_n_a;
        repeat (3) pulse_a(FA - 1, 2000);
        check_eq("a_glitch_count", 32'(gc_a), 32'd3);
        check_eq("a_glitch_level", 32'(lvl_n_a - l0), 32'd0);
        check_eq("a_glitch_no_det", 32'(det_n_a - d0), 32'd0);

        // Rises at 0, HA/2, HA (exact boundary), 2*HA-1 relative
        d0 = det_n_a;
        pulse_a(1200, 1300);
        pulse_a(1200, 1300);
        pulse_a(1200, HA - 1 - 1200);
        pulse_a(1200, 2000);
        check_eq("a_holdoff_det", 32'(det_n_a - d0), 32'd2);
        check_eq("a_holdoff_pcount", pc_a, 32'd3);
        check_eq("a_holdoff_rcount", 32'(rc_a), 32'd2);

        // Disabled: level follows, nothing counted
        d0 = det_n_a;
        en_a = 1'b0;
        sig_a = 1'b1;
        wait_a(1100);
        check_eq("a_dis_level_hi", 32'(lvl_a), 32'd1);
        sig_a = 1'b0;
        wait_a(1100);
        check_eq("a_dis_level_lo", 32'(lvl_a), 32'd0);
        sig_a = 1'b1;
        wait_a(1100);
        en_a = 1'b1;
        wait_a(500);
        check_eq("a_dis_no_det", 32'(det_n_a - d0), 32'd0);
        check_eq("a_dis_pcount", pc_a, 32'd3);
        check_eq("a_dis_gcount", 32'(gc_a), 32'd3);
        check_eq("a_dis_rcount", 32'(rc_a), 32'd2);
        sig_a = 1'b0;
        wait_a(1100);
        sig_a = 1'b1;
        wait_a(1100);
        check_eq("a_reen_det", 32'(det_n_a - d0), 32'd1);
        check_eq("a_reen_pcount", pc_a, 32'd4);

        // Reset mid rise-qualification while holdoff is still running
        sig_a = 1'b0;
        wait_a(1100);
        sig_a = 1'b1;
        wait_a(SA + 500);
        check_eq("a_pre_rst_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b0;
        #1;
        check_zero_a("a_rst_midqual");
        wait_a(3);
        rst_a = 1'b1;
        k  = cyc_a;
        d0 = det_n_a;
        wait_a(1100);
        check_eq("a_rel_det", 32'(det_n_a - d0), 32'd1);
        check_eq("a_rel_latency", 32'(det_cyc_a), 32'(k + 1 + SA + FA));
        wait_a(900);
        check_eq("a_pre_rst2_busy", 32'(busy_a), 32'd1);
        rst_a = 1'b0;
        #1;
        check_zero_a("a_rst_midhold");
        wait_a(3);
        rst_a = 1'b1;
        k = cyc_a;
        wait_a(1100);
        check_eq("a_rel2_latency", 32'(det_cyc_a), 32'(k + 1 + SA + FA));
        check_eq("a_rel2_pcount", pc_a, 32'd1);
        check_eq("a_rel2_level", 32'(lvl_a), 32'd1);
    endtask

    task automatic run_b();
        int k, d0;
        wait_b(4);
        check_eq("b_reset_pcount", 32'(pc_b), 32'd0);
        check_eq("b_reset_level", 32'(lvl_b), 32'd0);
        rst_b = 1'b1;
        wait_b(3);

        k  = cyc_b;
        d0 = det_n_b;
        sig_b = 1'b1;
        wait_b(6);
        check_eq("b_latency", 32'(det_cyc_b), 32'(k + 1 + SB + FB));
        check_eq("b_level_hi", 32'(lvl_b), 32'd1);
        sig_b = 1'b0;
        wait_b(6);
        repeat (16) begin
            sig_b = 1'b1;
            wait_b(4);
            sig_b = 1'b0;
            wait_b(4);
        end
        check_eq("b_det_count", 32'(det_n_b - d0), 32'd17);
        check_eq("b_pcount_wrap", 32'(pc_b), 32'd1);
        check_eq("b_never_busy", 32'(busy_n_b), 32'd0);
        check_eq("b_rcount", 32'(rc_b), 32'd0);
        check_eq("b_gcount_clean", 32'(gc_b), 32'd0);

        repeat (100) begin
            sig_b = 1'b1;
            wait_b(1);
            sig_b = 1'b0;
            wait_b(1);
        end
        wait_b(5);
        check_eq("b_gcount_100", 32'(gc_b), 32'd100);
        repeat (69900) begin
            sig_b = 1'b1;
            wait_b(1);
            sig_b = 1'b0;
            wait_b(1);
        end
        wait_b(5);
        check_eq("b_gcount_sat", 32'(gc_b), 32'h0000_FFFF);
        check_eq("b_glitch_no_det", 32'(det_n_b - d0), 32'd17);
        check_eq("b_glitch_level", 32'(lvl_b), 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; sig_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; sig_b = 1'b0; en_b = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
